// File: rtl/alu_pkg.sv
// Shared types for the ALU result checker: commands, status codes, FSM states
// and the expected-result entry held in the FIFO.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_AND = 3'b000,
        CMD_OR  = 3'b001,
        CMD_XOR = 3'b100,
        CMD_ADD = 3'b101,
        CMD_SUB = 3'b110
    } cmd_t;

    localparam logic [7:0] STS_NOERR  = 8'h00;
    localparam logic [7:0] STS_INVCMD = 8'h01;
    localparam logic [7:0] STS_ARGCNT = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_PUSH  = 2'b10
    } chk_state_t;

    // Entries carry a fixed-width data field so the type is independent of
    // DATA_W; result widths up to 64 bits (DATA_W <= 32) are supported.
    localparam int RES_W_MAX = 64;

    typedef struct packed {
        logic [7:0]           status;
        logic [RES_W_MAX-1:0] data;
    } exp_entry_t;

    function automatic logic cmd_is_valid(input logic [2:0] cmd);
        case (cmd)
            CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Operand and response stream tapped from the ALU under test.
interface alu_result_checker_if #(
    parameter int DATA_W = 8
);
    localparam int RES_W = 2 * DATA_W;

    logic              op_valid;
    logic [DATA_W-1:0] op_data;
    logic [2:0]        op_cmd;
    logic              op_last;
    logic              rsp_valid;
    logic [7:0]        rsp_status;
    logic [RES_W-1:0]  rsp_data;

    modport master (
        output op_valid, op_data, op_cmd, op_last,
        output rsp_valid, rsp_status, rsp_data
    );

    modport slave (
        input op_valid, op_data, op_cmd, op_last,
        input rsp_valid, rsp_status, rsp_data
    );

endinterface

// File: rtl/alu_exp_fifo.sv
// Synchronous FIFO for expected results; a pop in the same cycle frees a slot
// so a push into a full FIFO still succeeds.
module alu_exp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_result_checker.sv
// In-order result checker: rebuilds the expected ALU result from the operand
// stream, queues it, and scores each DUT response against the queue head.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for the first operand beat of an operation
//   S_ACCUM | folding further operand beats into the accumulator
//   S_PUSH  | one cycle: expected entry written into the FIFO
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_ARGS = 9,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_result_checker_if.slave       bus,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      ovf_err,
    output logic                      unf_err,
    output logic                      first_valid,
    output logic [8+2*DATA_W-1:0]     first_exp,
    output logic [8+2*DATA_W-1:0]     first_got,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      busy
);

    localparam int RES_W = 2 * DATA_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int ARG_W = $clog2(MAX_ARGS + 2);
    localparam int ENT_W = $bits(exp_entry_t);

    chk_state_t       state, state_nxt;
    logic [RES_W-1:0] acc, acc_nxt, acc_op, op_ext;
    logic [2:0]       cmd_q, cmd_nxt;
    logic [ARG_W-1:0] arg_cnt, arg_nxt, arg_inc;
    logic             push_req;

    exp_entry_t       push_ent;
    exp_entry_t       fifo_head;
    exp_entry_t       rsp_ent;
    logic             fifo_full, fifo_empty;
    logic             push_ok, pop_ok, drop;
    logic             pass_evt, fail_evt;
    logic [LVL_W-1:0] level_nxt;

    assign op_ext = RES_W'(bus.op_data);

    always_comb begin
        acc_op = acc;
        case (cmd_q)
            CMD_AND: acc_op = acc & op_ext;
            CMD_OR:  acc_op = acc | op_ext;
            CMD_XOR: acc_op = acc ^ op_ext;
            CMD_ADD: acc_op = acc + op_ext;
            CMD_SUB: acc_op = acc - op_ext;
            default: acc_op = acc;
        endcase
    end

    // Beat count sticks at MAX_ARGS+1, which is all the overrun check needs.
    assign arg_inc = (arg_cnt > ARG_W'(MAX_ARGS)) ? arg_cnt : arg_cnt + ARG_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            cmd_q   <= '0;
            arg_cnt <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cmd_q   <= cmd_nxt;
            arg_cnt <= arg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cmd_nxt   = cmd_q;
        arg_nxt   = arg_cnt;
        push_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    acc_nxt   = op_ext;
                    cmd_nxt   = bus.op_cmd;
                    arg_nxt   = ARG_W'(1);
                    state_nxt = bus.op_last ? S_PUSH : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.op_valid) begin
                    acc_nxt = acc_op;
                    arg_nxt = arg_inc;
                    if (bus.op_last) state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                push_req  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Argument overrun outranks an undefined command.
    always_comb begin
        push_ent = '0;
        if (arg_cnt > ARG_W'(MAX_ARGS)) begin
            push_ent.status = STS_ARGCNT;
        end else if (!cmd_is_valid(cmd_q)) begin
            push_ent.status = STS_INVCMD;
        end else begin
            push_ent.status = STS_NOERR;
            push_ent.data   = RES_W_MAX'(acc);
        end
    end

    assign rsp_ent.status = bus.rsp_status;
    assign rsp_ent.data   = RES_W_MAX'(bus.rsp_data);

    assign pop_ok    = bus.rsp_valid && !fifo_empty;
    assign push_ok   = push_req && (!fifo_full || pop_ok);
    assign drop      = push_req && !push_ok;
    assign pass_evt  = pop_ok && (fifo_head == rsp_ent);
    assign fail_evt  = bus.rsp_valid && !pass_evt;
    assign level_nxt = fifo_level + LVL_W'(push_ok) - LVL_W'(pop_ok);

    alu_exp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_exp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (bus.rsp_valid),
        .wdata (push_ent),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
            first_valid <= 1'b0;
            first_exp   <= '0;
            first_got   <= '0;
            busy        <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE) || (level_nxt != '0);
            if (pass_evt && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
            if (fail_evt && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
            if (drop) ovf_err <= 1'b1;
            if (bus.rsp_valid && fifo_empty) unf_err <= 1'b1;
            if (fail_evt && !first_valid) begin
                first_valid <= 1'b1;
                first_exp   <= pop_ok ? {fifo_head.status, fifo_head.data[RES_W-1:0]} : '0;
                first_got   <= {bus.rsp_status, bus.rsp_data};
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: expected entries are queued as
// operations are driven and consumed as responses are sent.
module tb_alu_result_checker;
    import alu_pkg::*;

    localparam int DATA_W   = 8;
    localparam int MAX_ARGS = 9;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_result_checker_if #(.DATA_W(DATA_W)) bus ();

    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic             ovf_err, unf_err, first_valid, busy;
    logic [23:0]      first_exp, first_got;
    logic [LVL_W-1:0] fifo_level;

    alu_result_checker #(
        .DATA_W   (DATA_W),
        .MAX_ARGS (MAX_ARGS),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err),
        .first_valid (first_valid),
        .first_exp   (first_exp),
        .first_got   (first_got),
        .fifo_level  (fifo_level),
        .busy        (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    int          m_pass, m_fail;
    bit          m_ovf, m_unf, m_fv;
    logic [23:0] m_fexp, m_fgot;
    logic [7:0]  b[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_op(input logic [2:0] cmd, input logic [7:0] beats[$]);
        logic [15:0] a;
        if (beats.size() > MAX_ARGS) return 24'h020000;
        if (!(cmd inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110})) return 24'h010000;
        a = {8'h00, beats[0]};
        for (int i = 1; i < beats.size(); i++) begin
            case (cmd)
                3'b000:  a = a & {8'h00, beats[i]};
                3'b001:  a = a | {8'h00, beats[i]};
                3'b100:  a = a ^ {8'h00, beats[i]};
                3'b101:  a = a + {8'h00, beats[i]};
                default: a = a - {8'h00, beats[i]};
            endcase
        end
        return {8'h00, a};
    endfunction

    function automatic void model_rsp(input logic [23:0] r);
        logic [23:0] e;
        bit ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (e == r);
        end else begin
            e     = 24'h0;
            ok    = 1'b0;
            m_unf = 1'b1;
        end
        if (ok) begin
            if (m_pass < CNT_MAX) m_pass++;
        end else begin
            if (m_fail < CNT_MAX) m_fail++;
            if (!m_fv) begin
                m_fv   = 1'b1;
                m_fexp = e;
                m_fgot = r;
            end
        end
    endfunction

    function automatic void model_push(input logic [23:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else m_ovf = 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".pass_cnt"},    pass_cnt,    m_pass);
        check_val({tag, ".fail_cnt"},    fail_cnt,    m_fail);
        check_val({tag, ".ovf_err"},     ovf_err,     m_ovf);
        check_val({tag, ".unf_err"},     unf_err,     m_unf);
        check_val({tag, ".first_valid"}, first_valid, m_fv);
        check_val({tag, ".first_exp"},   first_exp,   m_fexp);
        check_val({tag, ".first_got"},   first_got,   m_fgot);
        check_val({tag, ".fifo_level"},  fifo_level,  exp_q.size());
        check_val({tag, ".busy"},        busy,        exp_q.size() != 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n          = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_last    = 1'b0;
        bus.rsp_valid  = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n  = 1'b1;
        exp_q.delete();
        m_pass = 0;
        m_fail = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_fv   = 1'b0;
        m_fexp = '0;
        m_fgot = '0;
    endtask

    task automatic send_op(input logic [2:0] cmd, input logic [7:0] beats[$],
                           input bit rsp_in_push, input logic [23:0] rsp_val);
        logic [23:0] e;
        int lvl_before;
        e = model_op(cmd, beats);
        for (int i = 0; i < beats.size(); i++) begin
            @(negedge clk);
            bus.op_valid = 1'b1;
            bus.op_data  = beats[i];
            bus.op_cmd   = (i == 0) ? cmd : 3'($urandom);
            bus.op_last  = (i == beats.size() - 1);
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_last  = 1'b0;
        lvl_before   = exp_q.size();
        check_val("push_cycle.fifo_level", fifo_level, lvl_before);
        check_val("push_cycle.busy", busy, 1'b1);
        if (rsp_in_push) begin
            bus.rsp_valid = 1'b1;
            {bus.rsp_status, bus.rsp_data} = rsp_val;
            model_rsp(rsp_val);
        end
        model_push(e);
        @(negedge clk);
        bus.rsp_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [23:0] r);
        @(negedge clk);
        bus.rsp_valid = 1'b1;
        {bus.rsp_status, bus.rsp_data} = r;
        model_rsp(r);
        @(negedge clk);
        bus.rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] r;
        rst_n          = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_data    = '0;
        bus.op_cmd     = '0;
        bus.op_last    = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_status = '0;
        bus.rsp_data   = '0;
        do_reset(2);
        check_outputs("reset");

        // ADD 0xFF + 0x01 + 0x10 = 0x0110
        b = '{8'hFF, 8'h01, 8'h10};
        send_op(3'b101, b, 1'b0, 24'h0);
        check_outputs("add_queued");
        send_rsp(24'h000110);
        check_val("add.pass_cnt", pass_cnt, 1);
        check_outputs("add_done");

        // SUB 0x00 - 0x01 wraps to 0xFFFF; DUT answers 0x00FF
        b = '{8'h00, 8'h01};
        send_op(3'b110, b, 1'b0, 24'h0);
        send_rsp(24'h0000FF);
        check_val("sub.first_exp", first_exp, 24'h00FFFF);
        check_val("sub.first_got", first_got, 24'h0000FF);
        check_outputs("sub_done");

        // Invalid command, argument overrun, and exactly MAX_ARGS beats
        do_reset(1);
        b = '{8'h12, 8'h34, 8'h56};
        send_op(3'b111, b, 1'b0, 24'h0);
        b.delete();
        for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
        send_op(3'b001, b, 1'b0, 24'h0);
        check_val("err.fifo_level", fifo_level, 2);
        send_rsp(24'h010000);
        send_rsp(24'h020000);
        check_val("err.pass_cnt", pass_cnt, 2);
        b.delete();
        for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
        send_op(3'b001, b, 1'b0, 24'h0);
        send_rsp(exp_q[0]);
        check_outputs("max_args");

        // Overflow: five AND ops, no responses
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            b = '{8'($urandom), 8'($urandom)};
            send_op(3'b000, b, 1'b0, 24'h0);
        end
        check_val("ovf.fifo_level", fifo_level, 4);
        check_val("ovf.ovf_err", ovf_err, 1'b1);
        check_outputs("ovf_full");
        for (int k = 0; k < 4; k++) send_rsp(exp_q[0]);
        check_outputs("ovf_drain");

        // Same, but a response lands in the PUSH cycle of the fifth op
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            b = '{8'($urandom), 8'($urandom)};
            send_op(3'b000, b, 1'b0, 24'h0);
        end
        b = '{8'($urandom), 8'($urandom)};
        send_op(3'b000, b, 1'b1, exp_q[0]);
        check_val("ovf_pop.ovf_err", ovf_err, 1'b0);
        for (int k = 0; k < 4; k++) send_rsp(exp_q[0]);
        check_val("ovf_pop.pass_cnt", pass_cnt, 5);
        check_outputs("ovf_pop");

        // Response with nothing outstanding
        do_reset(1);
        send_rsp(24'h03ABCD);
        check_val("unf.unf_err", unf_err, 1'b1);
        check_val("unf.first_exp", first_exp, 24'h0);
        check_outputs("unf");

        // Single-beat XOR, then reset in the middle of an ADD
        do_reset(1);
        b = '{8'h5A};
        send_op(3'b100, b, 1'b0, 24'h0);
        send_rsp(24'h00005A);
        check_outputs("xor1");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.op_valid = 1'b1;
            bus.op_data  = 8'h40;
            bus.op_cmd   = 3'b101;
            bus.op_last  = 1'b0;
        end
        do_reset(1);
        check_outputs("mid_reset");
        b = '{8'h03, 8'h04};
        send_op(3'b101, b, 1'b0, 24'h0);
        send_rsp(24'h000007);
        check_outputs("after_reset");

        // Random operations, some responses corrupted; counters saturate
        do_reset(1);
        for (int k = 0; k < 40; k++) begin
            b.delete();
            for (int i = 0; i < int'($urandom_range(1, 11)); i++) b.push_back(8'($urandom));
            send_op(3'($urandom_range(0, 7)), b, 1'b0, 24'h0);
            r = exp_q[0];
            if ($urandom_range(0, 3) == 0) r = r ^ (24'h1 << $urandom_range(0, 23));
            send_rsp(r);
            check_outputs("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
